// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types for the fetch PC controller: FSM states, PC-source encoding, line size default.
// Pure declarations; no logic, no latency, no backpressure.
// Imported by the top and the redirect arbiter.
package fetch_pc_ctrl_pkg;

  localparam int LINE_BYTES_DEF = 16;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_MISS = 1'b1
  } fetch_state_e;

  typedef enum logic [2:0] {
    SRC_ROB = 3'd0,
    SRC_BR  = 3'd1,
    SRC_D1  = 3'd2,
    SRC_RAS = 3'd3,
    SRC_BP  = 3'd4,
    SRC_SEQ = 3'd5
  } redir_src_e;

endpackage

// File: rtl/fetch_redirect_arb.sv
// Fixed-priority redirect select: ROB > BR > D1 > RAS.
// Purely combinational, zero latency; no backpressure (losers are simply dropped).
module fetch_redirect_arb
  import fetch_pc_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            rob_v,
  input  logic [XLEN-1:0] rob_tgt,
  input  logic            br_v,
  input  logic [XLEN-1:0] br_tgt,
  input  logic            d1_v,
  input  logic [XLEN-1:0] d1_tgt,
  input  logic            ras_v,
  input  logic [XLEN-1:0] ras_tgt,
  output logic            redir_v,
  output logic [XLEN-1:0] redir_tgt,
  output redir_src_e      redir_src
);

  always_comb begin
    redir_v   = 1'b1;
    redir_tgt = rob_tgt;
    redir_src = SRC_ROB;
    if (rob_v) begin
      redir_tgt = rob_tgt;
      redir_src = SRC_ROB;
    end else if (br_v) begin
      redir_tgt = br_tgt;
      redir_src = SRC_BR;
    end else if (d1_v) begin
      redir_tgt = d1_tgt;
      redir_src = SRC_D1;
    end else if (ras_v) begin
      redir_tgt = ras_tgt;
      redir_src = SRC_RAS;
    end else begin
      redir_v   = 1'b0;
      redir_tgt = '0;
      redir_src = SRC_SEQ;
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC sequencer: redirects, branch prediction, I-cache request/response and miss wait.
// One outstanding request; fetch_v arrives with the response, one cycle after acceptance.
// stall_in holds issue but still delivers the in-flight response; redirects act under stall.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int LINE_BYTES = LINE_BYTES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_in,
  input  logic            rs_rob_v,
  input  logic            rs_br_v,
  input  logic            rs_d1_v,
  input  logic            rs_ras_v,
  input  logic [XLEN-1:0] rs_rob_tgt,
  input  logic [XLEN-1:0] rs_br_tgt,
  input  logic [XLEN-1:0] rs_d1_tgt,
  input  logic [XLEN-1:0] rs_ras_tgt,
  input  logic            bp_taken,
  input  logic [XLEN-1:0] bp_target,
  output logic            ic_req_v,
  input  logic            ic_req_rdy,
  output logic [XLEN-1:0] ic_req_pc,
  input  logic            ic_rsp_v,
  input  logic            ic_rsp_hit,
  input  logic            ic_refill_done,
  output logic            fetch_v,
  output logic [XLEN-1:0] fetch_pc,
  output logic            flush,
  output logic [15:0]     miss_cycles
);

  localparam logic [XLEN-1:0] LINE_INC  = XLEN'(LINE_BYTES);
  localparam logic [XLEN-1:0] LINE_MASK = ~(LINE_INC - XLEN'(1));

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic            epoch;
  logic            infl_v;
  logic [XLEN-1:0] infl_pc;
  logic            infl_epoch;
  logic            flush_q;
  logic [15:0]     miss_cnt;

  logic            redir_v;
  logic [XLEN-1:0] redir_tgt;
  redir_src_e      redir_src;
  redir_src_e      pc_src;
  logic [XLEN-1:0] next_pc;
  logic            req_acc;
  logic            rsp_ok;
  logic            rsp_miss;

  fetch_redirect_arb #(.XLEN(XLEN)) u_arb (
    .rob_v     (rs_rob_v),
    .rob_tgt   (rs_rob_tgt),
    .br_v      (rs_br_v),
    .br_tgt    (rs_br_tgt),
    .d1_v      (rs_d1_v),
    .d1_tgt    (rs_d1_tgt),
    .ras_v     (rs_ras_v),
    .ras_tgt   (rs_ras_tgt),
    .redir_v   (redir_v),
    .redir_tgt (redir_tgt),
    .redir_src (redir_src)
  );

  always_comb begin
    pc_src = SRC_SEQ;
    if (redir_v)       pc_src = redir_src;
    else if (bp_taken) pc_src = SRC_BP;
    case (pc_src)
      SRC_BP:  next_pc = bp_target;
      SRC_SEQ: next_pc = (pc & LINE_MASK) + LINE_INC;
      default: next_pc = redir_tgt;
    endcase
  end

  assign ic_req_v  = (state == ST_RUN) && !stall_in && !rst;
  assign ic_req_pc = pc;
  assign req_acc   = ic_req_v && ic_req_rdy;

  // A response is only trusted if it belongs to the current epoch and no redirect lands this cycle.
  assign rsp_ok      = ic_rsp_v && infl_v && (infl_epoch == epoch) && !redir_v && !rst;
  assign rsp_miss    = rsp_ok && !ic_rsp_hit && (state == ST_RUN);
  assign fetch_v     = rsp_ok && ic_rsp_hit;
  assign fetch_pc    = rst ? '0 : infl_pc;
  assign flush       = flush_q && !rst;
  assign miss_cycles = miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      pc         <= '0;
      epoch      <= 1'b0;
      infl_v     <= 1'b0;
      infl_pc    <= '0;
      infl_epoch <= 1'b0;
      flush_q    <= 1'b0;
      miss_cnt   <= '0;
    end else begin
      flush_q    <= redir_v;
      infl_v     <= req_acc;
      infl_pc    <= pc;
      infl_epoch <= epoch;
      if (state == ST_MISS && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;

      if (redir_v) begin
        pc    <= next_pc;
        state <= ST_RUN;
        epoch <= ~epoch;
      end else if (rsp_miss) begin
        // Rewind to the missed line; anything accepted this cycle is dropped.
        state  <= ST_MISS;
        pc     <= infl_pc;
        infl_v <= 1'b0;
      end else if (state == ST_MISS) begin
        if (ic_refill_done) state <= ST_RUN;
      end else if (req_acc) begin
        pc <= next_pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: I-cache responder model, expected-request and
// expected-fetch scoreboards popped by a negedge monitor, plus point checks.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_in = 1'b1;
  logic        rs_rob_v = 1'b0, rs_br_v = 1'b0, rs_d1_v = 1'b0, rs_ras_v = 1'b0;
  logic [31:0] rs_rob_tgt = '0, rs_br_tgt = '0, rs_d1_tgt = '0, rs_ras_tgt = '0;
  logic        bp_taken = 1'b0;
  logic [31:0] bp_target = 32'h400;
  logic        ic_req_v;
  logic        ic_req_rdy = 1'b1;
  logic [31:0] ic_req_pc;
  logic        ic_rsp_v = 1'b0, ic_rsp_hit = 1'b0, ic_refill_done = 1'b0;
  logic        fetch_v;
  logic [31:0] fetch_pc;
  logic        flush;
  logic [15:0] miss_cycles;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_req[$];
  logic [31:0] exp_fetch[$];

  logic        acc_s = 1'b0;
  logic [31:0] acc_pc_s = '0;
  logic [31:0] miss_pc = '0;
  bit          miss_armed = 1'b0;
  int          refill_delay = 5;
  int          rf_cnt = 0;
  bit          bp_en = 1'b0;

  fetch_pc_ctrl #(.XLEN(32), .LINE_BYTES(16)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in),
    .rs_rob_v(rs_rob_v), .rs_br_v(rs_br_v), .rs_d1_v(rs_d1_v), .rs_ras_v(rs_ras_v),
    .rs_rob_tgt(rs_rob_tgt), .rs_br_tgt(rs_br_tgt), .rs_d1_tgt(rs_d1_tgt), .rs_ras_tgt(rs_ras_tgt),
    .bp_taken(bp_taken), .bp_target(bp_target),
    .ic_req_v(ic_req_v), .ic_req_rdy(ic_req_rdy), .ic_req_pc(ic_req_pc),
    .ic_rsp_v(ic_rsp_v), .ic_rsp_hit(ic_rsp_hit), .ic_refill_done(ic_refill_done),
    .fetch_v(fetch_v), .fetch_pc(fetch_pc), .flush(flush), .miss_cycles(miss_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got 0x%0h, expected nothing", name, act);
  endtask

  // Monitor: pops scoreboards on every accepted request and every delivered line.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_quiet", {29'd0, fetch_v, flush, ic_req_v}, 32'd0);
    end else begin
      if (ic_req_v && ic_req_rdy) begin
        if (exp_req.size() == 0) unexpected("req_unexpected", ic_req_pc);
        else check("req_pc", ic_req_pc, exp_req.pop_front());
      end
      if (fetch_v) begin
        if (exp_fetch.size() == 0) unexpected("fetch_unexpected", fetch_pc);
        else check("fetch_pc", fetch_pc, exp_fetch.pop_front());
      end
    end
    acc_s    = ic_req_v && ic_req_rdy && !rst;
    acc_pc_s = ic_req_pc;
  end

  // I-cache and predictor model: response one cycle after acceptance, armed single miss.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ic_refill_done = 1'b0;
      if (rf_cnt > 0) begin
        rf_cnt--;
        if (rf_cnt == 0) ic_refill_done = 1'b1;
      end
      ic_rsp_v   = acc_s;
      ic_rsp_hit = 1'b1;
      if (acc_s && miss_armed && acc_pc_s == miss_pc) begin
        ic_rsp_hit = 1'b0;
        miss_armed = 1'b0;
        rf_cnt     = refill_delay;
      end
      bp_taken = bp_en && (ic_req_pc == 32'h20);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall_in = 1'b1;
    {rs_rob_v, rs_br_v, rs_d1_v, rs_ras_v} = 4'b0;
    exp_req.delete();
    exp_fetch.delete();
    bp_en = 1'b0;
    miss_armed = 1'b0;
    tick();
    tick();
    #1;
    check("rst_fetch_v", {31'd0, fetch_v}, 32'd0);
    check("rst_fetch_pc", fetch_pc, 32'd0);
    check("rst_miss_cycles", {16'd0, miss_cycles}, 32'd0);
    check("rst_ic_req_v", {31'd0, ic_req_v}, 32'd0);
  endtask

  task automatic phase_end(input string name);
    check({name, "_req_left"}, 32'(exp_req.size()), 32'd0);
    check({name, "_fetch_left"}, 32'(exp_fetch.size()), 32'd0);
  endtask

  initial begin
    // Sequential lines, then predicted-taken jump at 0x20.
    do_reset();
    bp_en = 1'b1;
    exp_req   = {32'h0, 32'h10, 32'h20, 32'h400, 32'h410};
    exp_fetch = {32'h0, 32'h10, 32'h20, 32'h400, 32'h410};
    tick(); rst = 1'b0; stall_in = 1'b0;
    repeat (5) tick();
    stall_in = 1'b1;
    tick(); tick();
    phase_end("seq_bp");

    // Miss on 0x40 with 5-cycle refill, then a 3-cycle stall at 0x60.
    do_reset();
    miss_pc = 32'h40; miss_armed = 1'b1; refill_delay = 5;
    exp_req   = {32'h0, 32'h10, 32'h20, 32'h30, 32'h40, 32'h50, 32'h40, 32'h50, 32'h60, 32'h70};
    exp_fetch = {32'h0, 32'h10, 32'h20, 32'h30, 32'h40, 32'h50, 32'h60, 32'h70};
    tick(); rst = 1'b0; stall_in = 1'b0;
    repeat (7) tick();
    #1 check("miss_no_req", {31'd0, ic_req_v}, 32'd0);
    repeat (4) tick();
    #1 check("miss_cycles_5", {16'd0, miss_cycles}, 32'd5);
    check("miss_reissue_pc", ic_req_pc, 32'h40);
    tick();
    tick(); stall_in = 1'b1;
    #1 check("stall_req_v", {31'd0, ic_req_v}, 32'd0);
    check("stall_pc_a", ic_req_pc, 32'h60);
    tick(); tick();
    #1 check("stall_pc_b", ic_req_pc, 32'h60);
    tick(); stall_in = 1'b0;
    tick();
    tick(); stall_in = 1'b1;
    tick(); tick();
    check("miss_cycles_hold", {16'd0, miss_cycles}, 32'd5);
    phase_end("miss_stall");

    // ROB beats BR on top of a hit response; then D1 beats RAS while stalled.
    do_reset();
    exp_req   = {32'h0, 32'h10, 32'h20, 32'h900, 32'h910, 32'hA00};
    exp_fetch = {32'h0, 32'h900, 32'h910, 32'hA00};
    tick(); rst = 1'b0; stall_in = 1'b0;
    tick();
    tick();
    rs_br_v = 1'b1; rs_br_tgt = 32'h800; rs_rob_v = 1'b1; rs_rob_tgt = 32'h900;
    #1 check("redir_flush_early", {31'd0, flush}, 32'd0);
    check("redir_rsp_dropped", {31'd0, fetch_v}, 32'd0);
    tick();
    rs_br_v = 1'b0; rs_rob_v = 1'b0;
    #1 check("redir_flush", {31'd0, flush}, 32'd1);
    check("redir_stale_rsp", {31'd0, fetch_v}, 32'd0);
    check("redir_pc", ic_req_pc, 32'h900);
    tick();
    #1 check("redir_flush_off", {31'd0, flush}, 32'd0);
    tick(); stall_in = 1'b1;
    tick();
    rs_d1_v = 1'b1; rs_d1_tgt = 32'hA00; rs_ras_v = 1'b1; rs_ras_tgt = 32'hB00;
    tick();
    rs_d1_v = 1'b0; rs_ras_v = 1'b0;
    #1 check("stall_redir_flush", {31'd0, flush}, 32'd1);
    check("stall_redir_pc", ic_req_pc, 32'hA00);
    check("stall_redir_no_req", {31'd0, ic_req_v}, 32'd0);
    tick(); stall_in = 1'b0;
    tick(); stall_in = 1'b1;
    tick(); tick();
    phase_end("redirect");

    // Reset in the middle of a miss; the late refill must be ignored.
    do_reset();
    miss_pc = 32'h10; miss_armed = 1'b1; refill_delay = 8;
    exp_req   = {32'h0, 32'h10, 32'h20};
    exp_fetch = {32'h0};
    tick(); rst = 1'b0; stall_in = 1'b0;
    repeat (5) tick();
    rst = 1'b1; stall_in = 1'b1;
    #1 check("pre_rst_miss_cycles", {16'd0, miss_cycles}, 32'd2);
    tick();
    tick(); rst = 1'b0;
    #1 check("post_rst_miss_cycles", {16'd0, miss_cycles}, 32'd0);
    check("post_rst_pc", ic_req_pc, 32'h0);
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h10);
    exp_fetch.push_back(32'h0);
    exp_fetch.push_back(32'h10);
    tick(); tick(); tick();
    tick(); stall_in = 1'b0;
    #1 check("refill_ignored_miss_cycles", {16'd0, miss_cycles}, 32'd0);
    check("refill_ignored_req_v", {31'd0, ic_req_v}, 32'd1);
    check("refill_ignored_pc", ic_req_pc, 32'h0);
    tick();
    tick(); stall_in = 1'b1;
    tick(); tick();
    phase_end("rst_in_miss");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
